seq_mult3x3: RTL and testbench
==============================

# seq_mult3x3

Sequential shift-and-add unsigned multiplier: accepts a W×W operand pair on a valid/ready input handshake, computes the product over W iterations using a W-bit ripple-carry adder built from `full_adder` cells, and presents the 2W-bit product on a valid/ready output handshake. It is the multi-cycle, area-minimal counterpart to the combinational 3x3 array multiplier. It sits directly downstream of the operand source and upstream of whatever consumes products. It reuses the existing `full_adder` cell as its arithmetic primitive.

## Interface
Parameters:
- `WIDTH`, default 3: operand width in bits; legal range 2..8.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operand pair on `a`/`b` is valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  multiplicand, unsigned.
- `b`  in  WIDTH  multiplier, unsigned.
- `out_valid`  out  1  `product` is valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the product.
- `product`  out  2*WIDTH  unsigned a*b.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Internal registers:
  - `mcand` (WIDTH) holds `a`.
  - `acc` (2*WIDTH) holds `{hi, lo}`.
  - `cnt` counts iterations from 0 to WIDTH.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `mcand`←a, `acc`←{0, b}, `cnt`←0, go to CALC.
- CALC, one iteration per cycle:
  - Adder computes `{cout, sum} = hi + (acc[0] ? mcand : 0)`.
  - Update: `acc` ← `{cout, sum, lo} >> 1`, `cnt`←cnt+1.
  - When the iteration being performed is number WIDTH (cnt==WIDTH-1), go to DONE.
- DONE:
  - `out_valid`=1 and `product`=`acc`.
  - On `out_valid && out_ready`, go to IDLE.
- `product` is driven from `acc` in every state. It is only meaningful while `out_valid`=1.
- Arithmetic rules:
  - Unsigned only.
  - The adder's WIDTH+1-bit result never overflows.
  - After WIDTH iterations `acc` equals a*b exactly; the maximum is (2^W−1)^2, which fits in 2W bits.
- `in_valid` while not in IDLE is ignored, because `in_ready`=0. Upstream must hold its data until accepted.
- `out_ready` outside DONE is ignored.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `acc`=0 (`product`=0), `cnt`=0, `mcand`=0.
- `rst` overrides any simultaneous handshake in the same cycle.
- Latency:
  - Operands are accepted at edge T.
  - Iterations occur at edges T+1..T+WIDTH.
  - `out_valid` rises in the cycle after edge T+WIDTH.
  - For WIDTH=3, the product is visible 3 cycles after acceptance.
- Throughput: one product per WIDTH+2 cycles at best, since IDLE lasts a minimum of one cycle between results. Input and output transfers never overlap.
- Backpressure: `out_valid` and `product` are held stable for as long as `out_ready`=0.
- Output and next input: the transfer completing at edge E returns the FSM to IDLE. `in_ready` is high in the following cycle, so the earliest next acceptance is at edge E+1.
- Reset mid-CALC or mid-DONE: the operation is abandoned and no product is emitted. Outputs take their reset values in the cycle after the reset edge.
- Outputs are combinational decodes of registered state only. There is no combinational path from an input to an output.

## Structure
- Package `mult_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t`.
  - Function/localparam for the counter width, `$clog2(WIDTH+1)`.
- Sub-module `ripple_adder #(WIDTH)`:
  - Ports `a`, `b`, `cin`, `sum`, `cout`.
  - A generate chain of WIDTH `full_adder` instances; `cin` is tied to 0 here.
  - It is separately testable and reusable by the array multiplier.
- Top level: FSM, counter, `acc`/`mcand` registers, and the operand-gating mux.

## Test plan
- Reset then a=7, b=7 with `out_ready`=1:
  - `out_valid` rises exactly 3 cycles after acceptance with `product`=49 (6'b110001).
  - `in_ready` returns to 1 the cycle after the output transfer.
- a=0, b=5 and a=5, b=0: `product`=0 in both cases, with the same latency as any other operands.
- Exhaustive sweep of all 64 (a, b) pairs, back-to-back with `in_valid` held high: each product equals a*b, with one result per 5 cycles.
- a=5, b=3 with `out_ready` held low for 6 cycles after `out_valid`:
  - `product`=15 and `out_valid`=1 stay stable throughout.
  - The transfer occurs on the first `out_ready`=1 edge.
- New operands (a=2, b=2) presented on `in_valid` during CALC and DONE: they are not accepted (`in_ready`=0), and the result of the in-flight operation is unaffected.
- Assert `rst` for one cycle during the second CALC iteration of a=6, b=3:
  - Next cycle: IDLE, `out_valid`=0, `product`=0.
  - No product is emitted.
  - A following a=3, b=3 yields 9.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the arithmetic primitive shared with the array multiplier.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built as a chain of full_adder cells.
module ripple_adder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult3x3.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on
// both sides; one partial-product iteration per cycle through a ripple adder.
module seq_mult3x3
    import mult_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = cnt_width(WIDTH);

    mult_state_t        state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [CW-1:0]      cnt_q,   cnt_d;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    assign hi     = acc_q[2*WIDTH-1:WIDTH];
    assign lo     = acc_q[WIDTH-1:0];
    assign addend = acc_q[0] ? mcand_q : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // NOTE: every next-state signal gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // {cout, sum, lo} >> 1, truncated back to 2*WIDTH bits.
                acc_d = {cout, sum, lo[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = acc_q;

endmodule

// File: tb/tb_seq_mult3x3.sv
// Scoreboard bench for seq_mult3x3: products expected on acceptance, compared on output transfer.
module tb_seq_mult3x3;

    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int             vectors    = 0;
    int             miscompares = 0;
    int             cyc        = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] sb_exp;

    seq_mult3x3 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accepted operands, pop and compare on product transfers.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back((2*W)'(a) * (2*W)'(b));
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard: unexpected product %0d with nothing outstanding", product);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (product !== sb_exp) begin
                        miscompares++;
                        $display("FAIL scoreboard: product %0d, expected %0d", product, sb_exp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and return once they have been accepted (edge passed).
    task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
        int n = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: in_ready never rose within 20 cycles", name);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles after acceptance until out_valid; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
        int lat;
        out_ready = 1'b1;
        accept_op(av, bv, name);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy: in_ready %b after acceptance, expected 0", name, in_ready);
        end
        wait_valid(lat);
        vectors++;
        if (lat !== W) begin
            miscompares++;
            $display("FAIL %s latency: %0d cycles, expected %0d", name, lat, W);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s return: in_ready %b out_valid %b, expected 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            miscompares++;
            $display("FAIL reset: in_ready %b out_valid %b product %0d, expected 1 0 0",
                     in_ready, out_valid, product);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset release: in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        run_op(3'd7, 3'd7, "mul_7x7");
    endtask

    task automatic test_zero();
        run_op(3'd0, 3'd5, "mul_0x5");
        run_op(3'd5, 3'd0, "mul_5x0");
    endtask

    task automatic test_back_to_back();
        int n;
        int prev = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            a = W'(i / 8);
            b = W'(i % 8);
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (i > 0) begin
                vectors++;
                if (cyc - prev !== W + 2) begin
                    miscompares++;
                    $display("FAIL sweep interval %0d: %0d cycles between accepts, expected %0d",
                             i, cyc - prev, W + 2);
                end
            end
            prev = cyc;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        accept_op(3'd5, 3'd3, "bp_5x3");
        wait_valid(lat);
        vectors++;
        if (lat !== W) begin
            miscompares++;
            $display("FAIL bp latency: %0d cycles, expected %0d", lat, W);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || product !== 6'd15) begin
                miscompares++;
                $display("FAIL bp hold %0d: out_valid %b product %0d, expected 1 15", i, out_valid, product);
            end
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp release: out_valid %b in_ready %b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_ignore_inflight();
        out_ready = 1'b0;
        accept_op(3'd4, 3'd6, "busy_4x6");
        a = 3'd2;
        b = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL busy ready %0d: in_ready %b, expected 0", i, in_ready);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b1 || product !== 6'd24) begin
            miscompares++;
            $display("FAIL busy result: out_valid %b product %0d, expected 1 24", out_valid, product);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_midcalc();
        out_ready = 1'b1;
        accept_op(3'd6, 3'd3, "rst_6x3");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            miscompares++;
            $display("FAIL midcalc reset: in_ready %b out_valid %b product %0d, expected 1 0 0",
                     in_ready, out_valid, product);
        end
        for (int i = 0; i < W + 2; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abandoned op %0d: out_valid %b, expected 0", i, out_valid);
            end
        end
        run_op(3'd3, 3'd3, "mul_3x3");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_ignore_inflight();
        test_reset_midcalc();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d products outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
